// File: rtl/conv_job_ctrl.sv
// conv_job_ctrl: frame job sequencing, image BRAM ownership and timeout watchdog for the Sobel core
module conv_job_ctrl #(
    parameter int          IMG_WIDTH      = 256,
    parameter int          IMG_HEIGHT     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_req,
    output logic        job_ack,
    output logic        job_busy,
    output logic        job_done,
    output logic        job_err,
    output logic [31:0] cycle_count,
    input  logic        host_wr_en,
    input  logic [31:0] host_wr_addr,
    input  logic [31:0] host_wr_data,
    output logic        host_wr_grant,
    input  logic        host_rd_en,
    input  logic [31:0] host_rd_addr,
    output logic [31:0] host_rd_data,
    output logic        host_rd_valid,
    output logic        conv_start,
    output logic        conv_rst_n,
    input  logic        conv_done,
    input  logic        conv_bram0_en,
    input  logic [31:0] conv_bram0_addr,
    output logic [31:0] conv_bram0_dout,
    input  logic [3:0]  conv_bram1_we,
    input  logic [31:0] conv_bram1_addr,
    input  logic [31:0] conv_bram1_din,
    output logic        bram0_en,
    output logic [3:0]  bram0_we,
    output logic [31:0] bram0_addr,
    output logic [31:0] bram0_din,
    input  logic [31:0] bram0_dout,
    output logic        bram1_en,
    output logic [3:0]  bram1_we,
    output logic [31:0] bram1_addr,
    output logic [31:0] bram1_din,
    input  logic [31:0] bram1_dout
);
    typedef enum logic [2:0] {IDLE, RUN, REL, ABORT, FIN} state_t;
    state_t state, state_nx;
    logic pending, pending_nx, ab, host_own, timeout, to_abort, accept, restart, pend_set;

    if (IMG_WIDTH < 1 || IMG_HEIGHT < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("conv_job_ctrl: invalid parameters");
    end

    assign host_own = state == IDLE || state == FIN;
    assign timeout  = cycle_count == 32'(TIMEOUT_CYCLES - 1);
    assign to_abort = state == RUN && !conv_done && timeout;
    // a request that lands on the aborting edge is lost along with the discarded pending slot
    assign pend_set = !host_own && job_req && !pending && !to_abort;

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        accept     = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                accept   = job_req;
                state_nx = job_req ? RUN : IDLE;
            end
            RUN:   state_nx = conv_done ? REL : to_abort ? ABORT : RUN;
            REL:   state_nx = conv_done ? REL : FIN;
            ABORT: state_nx = ab ? FIN : ABORT;
            FIN: begin
                restart  = pending;
                accept   = !pending && job_req;
                state_nx = pending || job_req ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (pend_set) pending_nx = 1'b1;
        if (to_abort || restart) pending_nx = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            ab            <= 1'b0;
            job_ack       <= 1'b0;
            job_err       <= 1'b0;
            cycle_count   <= 32'd0;
            host_rd_valid <= 1'b0;
        end else begin
            state         <= state_nx;
            pending       <= pending_nx;
            ab            <= state == ABORT && !ab;
            job_ack       <= accept || pend_set;
            job_err       <= (accept || restart) ? 1'b0 : to_abort ? 1'b1 : job_err;
            cycle_count   <= (accept || restart) ? 32'd0 :
                             (state == RUN && cycle_count != '1) ? cycle_count + 32'd1 : cycle_count;
            host_rd_valid <= host_own && host_rd_en;
        end
    end

    assign job_busy        = state != IDLE;
    assign job_done        = state == FIN;
    assign conv_start      = state == RUN;
    assign conv_rst_n      = rst_n && state != ABORT;
    assign host_wr_grant   = host_own;
    assign host_rd_data    = bram1_dout;
    assign conv_bram0_dout = host_own ? 32'd0 : bram0_dout;
    assign bram0_en        = host_own ? host_wr_en : conv_bram0_en;
    assign bram0_we        = host_own && host_wr_en ? 4'hF : 4'h0;
    assign bram0_addr      = host_own ? host_wr_addr : conv_bram0_addr;
    assign bram0_din       = host_own ? host_wr_data : 32'd0;
    assign bram1_en        = host_own ? host_rd_en : |conv_bram1_we;
    assign bram1_we        = host_own ? 4'h0 : conv_bram1_we;
    assign bram1_addr      = host_own ? host_rd_addr : conv_bram1_addr;
    assign bram1_din       = host_own ? 32'd0 : conv_bram1_din;
endmodule
